// File: rtl/bram_preload_seq.sv
// bram_preload_seq: streams WORD_CNT words from a valid/ready source into the BRAM preload (PL_*) chain.
// Define BRAM_PRELOAD_VERIFY_EN to add a readback pass that checks an 18-bit modular checksum.
module bram_preload_seq #(
    parameter int WADDR_W = 10,
    parameter int ID_W    = 9,
    parameter int DATA_W  = 18
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [ID_W-1:0]   tgt_id_i,
    input  logic              bcast_i,
    input  logic [WADDR_W-1:0] base_addr_i,
    input  logic [WADDR_W:0]  word_cnt_i,
    input  logic              s_valid_i,
    input  logic [DATA_W-1:0] s_data_i,
    output logic              s_ready_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic              pl_init_o,
    output logic              pl_ena_o,
    output logic              pl_wen_o,
    output logic              pl_ren_o,
    output logic [23:0]       pl_addr_o,
    output logic [DATA_W-1:0] pl_data_in_o,
    input  logic [DATA_W-1:0] pl_data_out_i
);
    typedef enum logic [1:0] {IDLE, WRITE, VERIFY, FIN} state_t;
    state_t state_q, state_d;
    logic [ID_W-1:0] id_q, id_d;
    logic bcast_q, bcast_d;
    logic [WADDR_W-1:0] base_q, base_d, addr_q, addr_d;
    logic [WADDR_W:0] cnt_q, cnt_d, rem_q, rem_d;
    logic [DATA_W-1:0] csum_q, csum_d, pl_din_q, pl_din_d;
    logic error_q, error_d, done_q, done_d;
    logic pl_init_q, pl_init_d, pl_ena_q, pl_ena_d, pl_wen_q, pl_wen_d, pl_ren_q, pl_ren_d;
    logic [23:0] pl_addr_q, pl_addr_d;
    logic hs, last;
`ifdef BRAM_PRELOAD_VERIFY_EN
    logic [DATA_W-1:0] rd_sum_q, rd_sum_d;
    logic rvalid_q, rvalid_d;
`else
    logic unused_rd;
    assign unused_rd = ^pl_data_out_i;
`endif
    // Gating ready with abort keeps a word from being accepted and then dropped.
    assign s_ready_o    = (state_q == WRITE) && !abort_i;
    assign busy_o       = state_q != IDLE;
    assign hs           = s_ready_o && s_valid_i;
    assign last         = rem_q == (WADDR_W + 1)'(1);
    assign done_o       = done_q;
    assign error_o      = error_q;
    assign pl_init_o    = pl_init_q;
    assign pl_ena_o     = pl_ena_q;
    assign pl_wen_o     = pl_wen_q;
    assign pl_ren_o     = pl_ren_q;
    assign pl_addr_o    = pl_addr_q;
    assign pl_data_in_o = pl_din_q;
    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        bcast_d  = bcast_q;
        base_d   = base_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        csum_d   = csum_q;
        error_d  = error_q;
        done_d   = 1'b0;
        pl_ena_d = 1'b0;
        pl_wen_d = 1'b0;
        pl_ren_d = 1'b0;
        pl_din_d = '0;
`ifdef BRAM_PRELOAD_VERIFY_EN
        rvalid_d = pl_ren_q;
        rd_sum_d = rvalid_q ? rd_sum_q + pl_data_out_i : rd_sum_q;
`endif
        case (state_q)
            IDLE: if (start_i) begin
                id_d    = tgt_id_i;
                bcast_d = bcast_i;
                base_d  = base_addr_i;
                cnt_d   = word_cnt_i;
                addr_d  = base_addr_i;
                rem_d   = word_cnt_i;
                csum_d  = '0;
                error_d = 1'b0;
                state_d = (word_cnt_i == '0) ? FIN : WRITE;
`ifdef BRAM_PRELOAD_VERIFY_EN
                rd_sum_d = '0;
`endif
            end
            WRITE: begin
                pl_ena_d = 1'b1;
                if (hs) begin
                    pl_wen_d = 1'b1;
                    pl_din_d = s_data_i;
                    addr_d   = addr_q + 1'b1;
                    rem_d    = rem_q - 1'b1;
                    csum_d   = csum_q + s_data_i;
                    if (last) begin
                        state_d = FIN;
`ifdef BRAM_PRELOAD_VERIFY_EN
                        if (!bcast_q) begin
                            state_d = VERIFY;
                            addr_d  = base_q;
                            rem_d   = cnt_q;
                        end
`endif
                    end
                end
            end
`ifdef BRAM_PRELOAD_VERIFY_EN
            // Reads retire one cycle after issue; compare only once the pipe is empty.
            VERIFY: if (rem_q != '0) begin
                pl_ena_d = 1'b1;
                pl_ren_d = 1'b1;
                addr_d   = addr_q + 1'b1;
                rem_d    = rem_q - 1'b1;
            end else if (!pl_ren_q && !rvalid_q) begin
                error_d = rd_sum_q != csum_q;
                state_d = FIN;
            end
`endif
            FIN: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort_i && state_q != IDLE) begin
            state_d  = IDLE;
            done_d   = 1'b0;
            pl_ena_d = 1'b0;
            pl_wen_d = 1'b0;
            pl_ren_d = 1'b0;
            pl_din_d = '0;
            error_d  = error_q;
        end
        pl_init_d = bcast_q && pl_ena_d;
        pl_addr_d = pl_ena_d ? 24'({id_q, 4'b0000, addr_q}) : '0;
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            id_q      <= '0;
            bcast_q   <= 1'b0;
            base_q    <= '0;
            cnt_q     <= '0;
            addr_q    <= '0;
            rem_q     <= '0;
            csum_q    <= '0;
            error_q   <= 1'b0;
            done_q    <= 1'b0;
            pl_init_q <= 1'b0;
            pl_ena_q  <= 1'b0;
            pl_wen_q  <= 1'b0;
            pl_ren_q  <= 1'b0;
            pl_addr_q <= '0;
            pl_din_q  <= '0;
`ifdef BRAM_PRELOAD_VERIFY_EN
            rd_sum_q  <= '0;
            rvalid_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            bcast_q   <= bcast_d;
            base_q    <= base_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            csum_q    <= csum_d;
            error_q   <= error_d;
            done_q    <= done_d;
            pl_init_q <= pl_init_d;
            pl_ena_q  <= pl_ena_d;
            pl_wen_q  <= pl_wen_d;
            pl_ren_q  <= pl_ren_d;
            pl_addr_q <= pl_addr_d;
            pl_din_q  <= pl_din_d;
`ifdef BRAM_PRELOAD_VERIFY_EN
            rd_sum_q  <= rd_sum_d;
            rvalid_q  <= rvalid_d;
`endif
        end
    end
endmodule

// File: tb/tb_bram_preload_seq.sv
// tb_bram_preload_seq: randomized loads checked against an expected write list and a model BRAM.
module tb_bram_preload_seq;
    logic clk = 1'b0, rst, start, abort, bcast, s_valid, s_ready, busy, done, error;
    logic pl_init, pl_ena, pl_wen, pl_ren;
    logic [8:0] tgt_id;
    logic [9:0] base_addr;
    logic [10:0] word_cnt;
    logic [17:0] s_data, pl_din, pl_dout;
    logic [23:0] pl_addr;
    int n_cmp = 0, n_bad = 0;
    always #5 clk = ~clk;
    bram_preload_seq dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .tgt_id_i(tgt_id),
        .bcast_i(bcast), .base_addr_i(base_addr), .word_cnt_i(word_cnt), .s_valid_i(s_valid),
        .s_data_i(s_data), .s_ready_o(s_ready), .busy_o(busy), .done_o(done), .error_o(error),
        .pl_init_o(pl_init), .pl_ena_o(pl_ena), .pl_wen_o(pl_wen), .pl_ren_o(pl_ren),
        .pl_addr_o(pl_addr), .pl_data_in_o(pl_din), .pl_data_out_i(pl_dout)
    );
    logic [17:0] ram [1024];
    int corrupt_addr = -1;
    always @(posedge clk) begin
        if (pl_wen) ram[pl_addr[9:0]] <= pl_din;
        if (pl_ren) pl_dout <= ram[pl_addr[9:0]] ^ ((int'(pl_addr[9:0]) == corrupt_addr) ? 18'h1 : 18'h0);
    end
    logic [23:0] wa_q [$];
    logic [17:0] wd_q [$];
    logic wi_q [$];
    logic [17:0] src [$];
    int done_cnt, ena_cnt, ren_cnt, bad_strobe;
    logic err_at_done, timed_out;
    always @(negedge clk) begin
        if (pl_wen) begin wa_q.push_back(pl_addr); wd_q.push_back(pl_din); wi_q.push_back(pl_init); end
        if (done) begin done_cnt++; err_at_done = error; end
        if (pl_ena) ena_cnt++;
        if (pl_ren) ren_cnt++;
        if ((pl_wen || pl_ren) && !pl_ena) bad_strobe++;
    end
    task automatic clear_mon();
        wa_q.delete(); wd_q.delete(); wi_q.delete();
        done_cnt = 0; ena_cnt = 0; ren_cnt = 0; bad_strobe = 0; err_at_done = 1'b0;
    endtask
    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask
    task automatic run_load(input logic [8:0] id, input logic bc, input logic [9:0] base,
                            input int cnt, input int gap, input bit toggle, input int restart_at);
        int i = 0, t = 0;
        logic hs;
        clear_mon();
        tgt_id = id; bcast = bc; base_addr = base; word_cnt = 11'(cnt); start = 1'b1; s_valid = 1'b0;
        cyc(1);
        start = 1'b0;
        while (i < cnt && t < 5000) begin
            start = (t == restart_at);
            if (start) begin tgt_id = ~id; base_addr = base + 10'd7; word_cnt = 11'd1; end
            s_valid = toggle ? !s_valid : ($urandom_range(99) >= gap);
            s_data = src[i];
            hs = s_valid && s_ready;
            cyc(1);
            if (hs) i++;
            t++;
        end
        s_valid = 1'b0; start = 1'b0;
        while (done_cnt == 0 && t < 5000) begin cyc(1); t++; end
        timed_out = t >= 5000;
        cyc(3);
    endtask
    task automatic test_load(input string nm, input logic [8:0] id, input logic bc, input logic [9:0] base,
                             input int cnt, input int gap, input bit toggle, input int restart_at);
        logic exp_err = 1'b0;
        int exp_ren = 0;
`ifdef BRAM_PRELOAD_VERIFY_EN
        exp_ren = bc ? 0 : cnt;
        for (int i = 0; i < cnt; i++) if ((int'(base) + i) % 1024 == corrupt_addr) exp_err = !bc;
`endif
        run_load(id, bc, base, cnt, gap, toggle, restart_at);
        n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL %s timeout: got %0b want 0", nm, timed_out); end
        n_cmp++; if (wa_q.size() !== cnt) begin n_bad++; $display("FAIL %s wen_count: got %0d want %0d", nm, wa_q.size(), cnt); end
        for (int i = 0; i < cnt && i < wa_q.size(); i++) begin
            logic [23:0] ea = 24'(int'(id) * 16384 + (int'(base) + i) % 1024);
            n_cmp++; if (wa_q[i] !== ea) begin n_bad++; $display("FAIL %s addr[%0d]: got %06h want %06h", nm, i, wa_q[i], ea); end
            n_cmp++; if (wd_q[i] !== src[i]) begin n_bad++; $display("FAIL %s data[%0d]: got %05h want %05h", nm, i, wd_q[i], src[i]); end
            n_cmp++; if (wi_q[i] !== bc) begin n_bad++; $display("FAIL %s init[%0d]: got %0b want %0b", nm, i, wi_q[i], bc); end
        end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL %s done_count: got %0d want 1", nm, done_cnt); end
        n_cmp++; if (err_at_done !== exp_err) begin n_bad++; $display("FAIL %s error: got %0b want %0b", nm, err_at_done, exp_err); end
        n_cmp++; if (ren_cnt !== exp_ren) begin n_bad++; $display("FAIL %s ren_count: got %0d want %0d", nm, ren_cnt, exp_ren); end
        n_cmp++; if (bad_strobe !== 0) begin n_bad++; $display("FAIL %s strobe_without_ena: got %0d want 0", nm, bad_strobe); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL %s busy_after: got %0b want 0", nm, busy); end
    endtask
    task automatic test_reset();
        rst = 1'b1; start = 0; abort = 0; bcast = 0; s_valid = 0; s_data = 0; tgt_id = 0; base_addr = 0; word_cnt = 0;
        #2;
        n_cmp++; if ({s_ready, busy, done, error, pl_init, pl_ena, pl_wen, pl_ren} !== 8'h0) begin n_bad++; $display("FAIL reset_flags: got %02h want 00", {s_ready, busy, done, error, pl_init, pl_ena, pl_wen, pl_ren}); end
        n_cmp++; if ({pl_addr, pl_din} !== 42'h0) begin n_bad++; $display("FAIL reset_bus: got %011h want 0", {pl_addr, pl_din}); end
        cyc(1); rst = 1'b0; cyc(1);
    endtask
    task automatic test_basic();
        src = '{18'd1, 18'd2, 18'd3, 18'd4};
        test_load("basic", 9'd5, 1'b0, 10'd0, 4, 0, 1'b0, -1);
    endtask
    task automatic test_wrap();
        src = '{18'h1a, 18'h2b, 18'h3c, 18'h4d};
        test_load("wrap", 9'd3, 1'b0, 10'd1022, 4, 0, 1'b1, -1);
    endtask
    task automatic test_random();
        for (int k = 0; k < 4; k++) begin
            int n = $urandom_range(40, 1);
            src.delete();
            for (int i = 0; i < n; i++) src.push_back(18'($urandom));
            test_load("random", 9'($urandom_range(511)), 1'b0, 10'($urandom_range(1023)), n, 30, 1'b0, -1);
        end
    endtask
    task automatic test_bcast();
        src = '{18'h3ffff, 18'h00001, 18'h15555};
        test_load("bcast", 9'd17, 1'b1, 10'd100, 3, 20, 1'b0, -1);
    endtask
    task automatic test_busy_start();
        src = '{18'h11, 18'h22, 18'h33, 18'h44, 18'h55};
        test_load("busy_start", 9'd7, 1'b0, 10'd40, 5, 0, 1'b0, 1);
    endtask
    task automatic test_zero();
        clear_mon();
        tgt_id = 9'd1; bcast = 1'b0; base_addr = 10'd9; word_cnt = 11'd0; start = 1'b1;
        cyc(1); start = 1'b0;
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL zero_done_early: got %0b want 0", done); end
        cyc(1);
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL zero_done_at_2: got %0b want 1", done); end
        cyc(3);
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL zero_done_count: got %0d want 1", done_cnt); end
        n_cmp++; if (ena_cnt !== 0) begin n_bad++; $display("FAIL zero_ena: got %0d want 0", ena_cnt); end
    endtask
    task automatic test_abort();
        src.delete();
        for (int i = 0; i < 8; i++) src.push_back(18'($urandom));
        clear_mon();
        tgt_id = 9'd2; bcast = 1'b0; base_addr = 10'd500; word_cnt = 11'd8; start = 1'b1;
        cyc(1); start = 1'b0;
        for (int i = 0; i < 2; i++) begin s_valid = 1'b1; s_data = src[i]; cyc(1); end
        s_valid = 1'b0; abort = 1'b1;
        cyc(1); abort = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %0b want 0", busy); end
        n_cmp++; if ({pl_ena, pl_wen, pl_ren, pl_init} !== 4'h0) begin n_bad++; $display("FAIL abort_pl: got %01h want 0", {pl_ena, pl_wen, pl_ren, pl_init}); end
        cyc(5);
        n_cmp++; if (done_cnt !== 0) begin n_bad++; $display("FAIL abort_done: got %0d want 0", done_cnt); end
        n_cmp++; if (wa_q.size() !== 2) begin n_bad++; $display("FAIL abort_writes: got %0d want 2", wa_q.size()); end
        src = '{18'h5, 18'h6, 18'h7};
        test_load("after_abort", 9'd4, 1'b0, 10'd8, 3, 10, 1'b0, -1);
    endtask
    task automatic test_rst_mid();
        clear_mon();
        tgt_id = 9'd3; bcast = 1'b0; base_addr = 10'd0; word_cnt = 11'd6; start = 1'b1;
        cyc(1); start = 1'b0;
        for (int i = 0; i < 2; i++) begin s_valid = 1'b1; s_data = 18'h2aaaa; cyc(1); end
        s_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_cmp++; if ({busy, s_ready, pl_ena, pl_wen, pl_init} !== 5'h0) begin n_bad++; $display("FAIL rst_mid_flags: got %02h want 00", {busy, s_ready, pl_ena, pl_wen, pl_init}); end
        n_cmp++; if ({pl_addr, pl_din} !== 42'h0) begin n_bad++; $display("FAIL rst_mid_bus: got %011h want 0", {pl_addr, pl_din}); end
        cyc(1); rst = 1'b0; cyc(3);
        n_cmp++; if (done_cnt !== 0) begin n_bad++; $display("FAIL rst_mid_done: got %0d want 0", done_cnt); end
    endtask
`ifdef BRAM_PRELOAD_VERIFY_EN
    task automatic test_verify();
        src = '{18'h3ffff, 18'h00001, 18'h00002};
        corrupt_addr = -1;
        test_load("verify_ok", 9'd6, 1'b0, 10'd200, 3, 0, 1'b0, -1);
        corrupt_addr = 201;
        test_load("verify_bad", 9'd6, 1'b0, 10'd200, 3, 25, 1'b0, -1);
        corrupt_addr = -1;
    endtask
`endif
    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_random();
        test_bcast();
        test_busy_start();
        test_zero();
        test_abort();
`ifdef BRAM_PRELOAD_VERIFY_EN
        test_verify();
`endif
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
